// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// the halt sentinel and the fetch FSM state encoding.
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_prog_mem.sv
// Program memory: DEPTH x DATA_W array, single write port, registered read.
// A write to the address being read is forwarded so the read sees the new word.
`default_nettype none

module instr_fetch_unit_prog_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory plus a pc-driven FSM that issues one
// word at a time and advances only when the processor signals completion.
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       DEPTH     = DEPTH_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              done_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] iin_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              running_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iin_q, iin_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_we;

  assign mem_we = wr_en_i && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  // Reading at pc_d makes the word for the next FETCH cycle available
  // at the edge that enters FETCH, giving the two-edge issue latency.
  instr_fetch_unit_prog_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (pc_d),
    .rd_data_o (mem_rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iin_d   = iin_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        iin_d   = '0;
        valid_d = 1'b0;
        if (start_i) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (mem_rd_data != HALT_WORD) begin
          iin_d   = mem_rd_data;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          iin_d   = '0;
          valid_d = 1'b0;
          state_d = ST_HALT;
        end
      end
      ST_ISSUE: begin
        if (done_i) begin
          iin_d   = '0;
          valid_d = 1'b0;
          // The last address halts instead of wrapping back to zero.
          if (pc_q == LAST_ADDR) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        iin_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      iin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iin_q   <= iin_d;
      valid_q <= valid_d;
    end
  end

  assign iin_o     = iin_q;
  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign running_o = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
  assign halted_o  = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory-image model predicts the
// issued word sequence, a monitor pops and compares on every new issue.
`default_nettype none

module tb_instr_fetch_unit;

  localparam int          DEPTH = 32;
  localparam logic [15:0] HALT  = 16'hFFFF;

  typedef struct packed {
    logic [4:0]  pc;
    logic [15:0] word;
  } exp_t;

  logic        clk, rst_n, start, done, wr_en;
  logic [4:0]  wr_addr, pc;
  logic [15:0] wr_data, iin;
  logic        valid, running, halted;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_mem [DEPTH];
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        mon_pv;
  logic [15:0] mon_pi;

  instr_fetch_unit dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .done_i    (done),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .iin_o     (iin),
    .valid_o   (valid),
    .pc_o      (pc),
    .running_o (running),
    .halted_o  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every rising valid is one issued instruction.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pv <= 1'b0;
    end else begin
      if (valid && !mon_pv) begin
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_word", 32'(iin), 32'(mon_e.word));
          check("issue_pc", 32'(pc), 32'(mon_e.pc));
        end
      end else if (valid && mon_pv) begin
        check("issue_hold", 32'(iin), 32'(mon_pi));
      end
      mon_pv <= valid;
      mon_pi <= iin;
    end
  end

  task automatic mem_write(input int addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic check_quiet(input string name, input logic [4:0] exp_pc, input logic exp_halt);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_iin"}, 32'(iin), 32'd0);
    check({name, "_pc"}, 32'(pc), 32'(exp_pc));
    check({name, "_running"}, 32'(running), 32'd0);
    check({name, "_halted"}, 32'(halted), 32'(exp_halt));
  endtask

  // ack_fixed=0 gives a random ack delay; inj exercises ignored write/start;
  // ws writes mem[0] in the start cycle; abort_at>=0 resets while issuing that pc.
  task automatic run_program(input int ack_fixed, input bit inj, input bit ws,
                             input logic [15:0] wsd, input int abort_at);
    int n, hpc, ack;
    if (ws) model_mem[0] = wsd;
    n = 0; hpc = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (model_mem[a] == HALT) begin hpc = a; break; end
      exp_q.push_back('{pc: 5'(a), word: model_mem[a]});
      n++;
    end
    @(negedge clk);
    start = 1'b1;
    if (ws) begin wr_en = 1'b1; wr_addr = 5'd0; wr_data = wsd; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("start_running", 32'(running), 32'd1);
    check("start_valid_low", 32'(valid), 32'd0);
    @(negedge clk);
    if (n == 0) check_quiet("halt_first", 5'd0, 1'b1);
    else        check("first_valid", 32'(valid), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_quiet("async_rst", 5'd0, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ack = (ack_fixed > 0) ? ack_fixed : int'($urandom_range(4, 1));
      for (int k = 1; k < ack; k++) begin
        if (inj && i == 0 && k == 1) begin wr_en = 1'b1; wr_addr = 5'd1; wr_data = 16'h1234; end
        if (inj && i == 1 && k == 1) start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        check("held_valid", 32'(valid), 32'd1);
        check("held_pc", 32'(pc), 32'(i));
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("bubble_valid", 32'(valid), 32'd0);
      @(negedge clk);
      if (i < n - 1) check("next_valid", 32'(valid), 32'd1);
    end
    if (n > 0) check_quiet("end_halt", 5'(hpc), 1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; done = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset", 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_quiet("idle", 5'd0, 1'b0);
    end

    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check_quiet("done_in_idle", 5'd0, 1'b0);

    for (int a = 0; a < DEPTH; a++) mem_write(a, 16'($urandom_range(16'hFFFE, 0)));

    mem_write(0, 16'hA01C); mem_write(1, 16'hA40A); mem_write(2, 16'h2080);
    mem_write(3, 16'h8000); mem_write(4, HALT);
    run_program(3, 1'b0, 1'b0, 16'h0, -1);

    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check_quiet("done_in_halt", 5'd4, 1'b1);

    mem_write(0, HALT);
    run_program(3, 1'b0, 1'b0, 16'h0, -1);

    run_program(3, 1'b0, 1'b1, 16'h5A5A, -1);

    run_program(3, 1'b1, 1'b0, 16'h0, -1);

    run_program(3, 1'b0, 1'b0, 16'h0, 2);
    run_program(2, 1'b0, 1'b0, 16'h0, -1);

    for (int a = 0; a < DEPTH; a++) mem_write(a, 16'h2080);
    run_program(0, 1'b0, 1'b0, 16'h0, -1);

    for (int r = 0; r < 4; r++) begin
      int hpos;
      hpos = int'($urandom_range(40, 0));
      for (int a = 0; a < DEPTH; a++)
        mem_write(a, (a == hpos) ? HALT : 16'($urandom_range(16'hFFFE, 0)));
      run_program(0, 1'b0, 1'b0, 16'h0, -1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream instruction-supply stage for the 16-bit processor. Holds a small writable program memory and a program counter, and presents one instruction word at a time on iin. It advances to the next word only when the processor pulses done. Replaces hand-driven iin stimulus, so programs run back-to-back from memory.

Parameters:
DATA_W, 16, instruction width; matches processor iin.
DEPTH, 32, program memory words.
ADDR_W, 5, address/pc width; DEPTH == 2**ADDR_W.
HALT_WORD, 16'hFFFF, instruction value that stops fetching; never issued.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins execution at address 0.
done  in  1  processor pulse: current instruction completed.
wr_en  in  1  program-memory write strobe.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
iin  out  DATA_W  instruction to processor.
valid  out  1  iin holds an issued instruction.
pc  out  ADDR_W  address of current/next fetch.
running  out  1  state is FETCH or ISSUE.
halted  out  1  state is HALT.

Behaviour:
- Reset (async, resetn=0): state IDLE, pc=0, iin=0, valid=0, running=0, halted=0. Memory contents are not reset.
- States: IDLE, FETCH, ISSUE, HALT. All transitions on rising clock edge.
- IDLE: start=1 -> FETCH, pc=0.
- FETCH (1 cycle): read mem[pc].
  - Word != HALT_WORD -> iin=word, valid=1, go ISSUE.
  - Word == HALT_WORD -> iin=0, valid=0, go HALT.
- ISSUE: iin and valid held stable until done=1.
  - On done with pc == DEPTH-1 -> valid=0, iin=0, go HALT. No wrap-around.
  - Otherwise pc=pc+1, valid=0, go FETCH.
- HALT: outputs hold (valid=0, iin=0). start=1 -> FETCH, pc=0.
- Latency: start at edge n gives valid iin after edge n+2. done sampled at edge n gives the next valid iin after edge n+2, with one bubble cycle where valid=0.
- Writes: accepted only in IDLE or HALT, mem[wr_addr]=wr_data at the edge. Ignored in FETCH and ISSUE.
- wr_en and start in the same IDLE cycle: the write commits, and the following FETCH of that address returns the new data.
- start while running: ignored. done outside ISSUE: ignored.
- done held high across multiple cycles: each ISSUE cycle with done=1 counts as a completion. The processor must pulse done.
- resetn asserted mid-operation: immediate return to reset values. pc is lost and memory is retained.
- pc arithmetic is unsigned ADDR_W-bit; the increment never overflows because of the DEPTH-1 halt rule.
- Outputs are registered; no combinational path from done to iin.

Decomposition:
- Shared package / constants header (fetch_defs):
  - state encoding localparams ST_IDLE=0, ST_FETCH=1, ST_ISSUE=2, ST_HALT=3.
  - HALT_WORD default.
  - DATA_W default 16.
- One natural sub-module: prog_mem, a single-port-write, registered-read DEPTH x DATA_W array. Fetch FSM and pc live in instr_fetch_unit.

Test Plan:
1. Reset then idle: resetn=0 for 3 cycles, release, no start -> iin=0, valid=0, pc=0, running=0, halted=0 for 10 cycles.
2. Program run: write 16'hA01C, 16'hA40A, 16'h2080, 16'h8000, 16'hFFFF to addresses 0-4; pulse start; pulse done 3 cycles after each valid rise -> iin shows the four words in order, each held until done, one valid=0 bubble between words; after the 4th done, halted=1 and pc=4.
3. Halt word first: mem[0]=16'hFFFF; start -> halted=1 two edges later; valid never asserted; iin stays 0.
4. End of memory: fill all 32 words with 16'h2080 (no halt word); start and ack each word -> after the 32nd done, halted=1, pc=31, no wrap to 0.
5. Write and start protection:
   - wr_en to address 1 with 16'h1234 while ISSUE at pc=0 -> ignored; mem[1] keeps its old value when fetched.
   - start pulse mid-run -> pc unchanged.
   - done pulsed in IDLE -> no state change.
6. Async reset mid-ISSUE at pc=2: resetn low between clock edges -> iin=0, valid=0, pc=0 immediately. After release and start, iin=mem[0] is re-issued with contents intact.
